ieee1355_tx_scheduler: RTL and testbench
========================================

Name: ieee1355_tx_scheduler

Overview:
- Shares one IEEE1355 DS transmit lane between G_NUM_REQ character requesters.
- Generates bit and character-slot timing from clk_x4.
- After link enable, runs a NULL preamble; then grants one 10-bit character per slot, round-robin, and fills empty slots with NULL (10'b1111000110, bit0 sent first).
- Drives a downstream DS serializer through a char_out/char_load strobe interface.

Parameters:
- G_NUM_REQ, 4: number of requesters (2..8).
- G_CLK_PER_BIT, 4: clk_x4 cycles per transmitted bit (≥2).
- G_NULL_PRE, 8: NULL characters sent after link enable before the first grant (1..255).

Ports:
- clk_x4  in  1  sampling/system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- link_en  in  1  link enable; low forces NULL-only transmission.
- req_valid  in  G_NUM_REQ  per-requester character pending.
- req_data  in  10*G_NUM_REQ  requester i character at bits [10i+9:10i].
- req_ack  out  G_NUM_REQ  one-cycle pulse; requester i's character has been taken.
- char_out  out  10  character for the serializer; held between loads.
- char_load  out  1  one-cycle pulse; serializer latches char_out.
- bit_en  out  1  one-cycle pulse per bit period; serializer shift enable.
- link_up  out  1  high in RUN state.
- tx_char_count  out  16  count of granted (non-NULL) characters; wraps at 0xFFFF->0.

Behaviour:
- Reset values:
  - prescaler = 0, bit_idx = 0, FSM = DISABLED, rr_ptr = 0.
  - char_out = NULL; char_load, bit_en, req_ack = 0.
  - link_up = 0, tx_char_count = 0, preamble count = 0.
- Prescaler:
  - Counts 0..G_CLK_PER_BIT-1; bit_en is registered and high for the cycle after count = G_CLK_PER_BIT-1.
  - bit_idx counts 0..9 on bit_en and wraps.
- Slot strobe (internal): bit_en high and bit_idx = 9. One strobe every 10*G_CLK_PER_BIT cycles.
- At each slot strobe, in the same cycle, register the selection. On the next cycle:
  - char_load = 1.
  - char_out = the selected character or NULL.
  - req_ack[i] = 1 for a granted requester.
  - tx_char_count increments on a grant.
- FSM states:
  - DISABLED: no grants. If link_en = 1, go to PREAMBLE and clear the preamble count.
  - PREAMBLE: every slot loads NULL and increments the preamble count. At the slot strobe where the count reaches G_NULL_PRE, go to RUN on the next cycle. link_en = 0 returns to DISABLED.
  - RUN: link_up = 1. At a slot strobe with link_en = 1 and any req_valid, grant the first valid requester scanning from rr_ptr upward, modulo G_NUM_REQ. Then set rr_ptr = granted + 1 (mod). With no valid requester, load NULL and leave rr_ptr unchanged. link_en = 0 goes to DISABLED next cycle.
- Selection priority: grants require state = RUN and link_en = 1 at the strobe cycle. If link_en falls on the strobe cycle, that slot is NULL, no ack is issued, and the FSM goes to DISABLED.
- Requester rules:
  - req_valid and req_data must stay stable until req_ack.
  - A requester may deassert req_valid before ack (withdraw); that withdrawal is never granted.
  - At most one req_ack bit is high per cycle, and only coincident with char_load.
- Timing is free-running in all states: bit_en and char_load continue in DISABLED, so the lane always carries NULLs.
- Slot timing is not realigned by link_en.
- Asynchronous reset mid-character:
  - All state returns to reset values immediately.
  - A pending request is not acked and must be re-presented.
  - Any partially sent character is abandoned (the serializer resets on the same rst_n).

Test Plan:
- Reset, link_en = 1, no requests, defaults:
  - bit_en period 4 cycles; char_load period exactly 40 cycles.
  - Every char_out = 10'b1111000110.
  - link_up rises the cycle after the strobe of the 8th load.
- req_valid[2] = 1 with data 10'h155 from reset release:
  - Loads 1–8 are NULL and req_ack stays 0.
  - Load 9 has char_out = 10'h155 and req_ack = 4'b0100.
  - tx_char_count = 1.
- All four requesters valid continuously in RUN with data 0x001/0x002/0x003/0x004:
  - Loads carry 0x001, 0x002, 0x003, 0x004, 0x001.
  - Acks are one-hot in order 0, 1, 2, 3, 0.
- link_en = 0 in RUN with req_valid[1] held:
  - link_up falls and following loads are NULL with no ack.
  - On link_en = 1, 8 NULL loads follow, then requester 1 is granted.
- link_en falls on the slot-strobe cycle while req_valid[0] = 1: that load is NULL, req_ack = 0, next state DISABLED.
- rst_n asserted mid-slot after tx_char_count = 5:
  - Outputs immediately return to reset values (count 0, char_out = NULL, link_up = 0).
  - After release, the preamble restarts.

Source files
------------

// File: rtl/ieee1355_tx_scheduler.sv
// IEEE1355 DS transmit-lane scheduler: free-running bit/slot timing, NULL preamble
// after link enable, then one round-robin-granted character per slot (NULL when idle).
module ieee1355_tx_scheduler #(
    parameter int G_NUM_REQ     = 4,
    parameter int G_CLK_PER_BIT = 4,
    parameter int G_NULL_PRE    = 8
) (
    input  logic                     clk_x4,
    input  logic                     rst_n,
    input  logic                     link_en,
    input  logic [G_NUM_REQ-1:0]     req_valid,
    input  logic [10*G_NUM_REQ-1:0]  req_data,
    output logic [G_NUM_REQ-1:0]     req_ack,
    output logic [9:0]               char_out,
    output logic                     char_load,
    output logic                     bit_en,
    output logic                     link_up,
    output logic [15:0]              tx_char_count
);

    localparam logic [9:0] NULL_CHAR = 10'b1111000110;
    localparam int         PTR_W     = $clog2(G_NUM_REQ);
    localparam int         CNT_W     = $clog2(G_CLK_PER_BIT);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_PREAMBLE,
        ST_RUN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   prescaler;
    logic [3:0]         bit_idx;
    logic [7:0]         pre_cnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic               slot_strobe;

    logic [9:0]         req_char [G_NUM_REQ];
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     cand_sum;
    logic [PTR_W-1:0]   cand_idx;

    for (genvar i = 0; i < G_NUM_REQ; i++) begin : g_unpack
        assign req_char[i] = req_data[10*i +: 10];
    end

    // Bit and slot timing run in every state so the lane always carries characters.
    always_ff @(posedge clk_x4 or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            bit_en    <= 1'b0;
            bit_idx   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            bit_en    <= (prescaler == CNT_W'(G_CLK_PER_BIT - 1));
            prescaler <= (prescaler == CNT_W'(G_CLK_PER_BIT - 1)) ? '0 : prescaler + 1'b1;
            if (bit_en)
                bit_idx <= (bit_idx == 4'd9) ? 4'd0 : bit_idx + 4'd1;
        end
    end

    assign slot_strobe = bit_en && (bit_idx == 4'd9);

    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand_idx    = '0;
        // Scan downward so the surviving hit is the first valid requester from rr_ptr.
        for (int k = G_NUM_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand_sum >= (PTR_W+1)'(G_NUM_REQ))
                cand_sum = cand_sum - (PTR_W+1)'(G_NUM_REQ);
            cand_idx = cand_sum[PTR_W-1:0];
            if (req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk_x4 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_DISABLED;
            pre_cnt       <= '0;
            rr_ptr        <= '0;
            char_out      <= NULL_CHAR;
            char_load     <= 1'b0;
            req_ack       <= '0;
            link_up       <= 1'b0;
            tx_char_count <= '0;
        end else begin
            char_load <= 1'b0;
            req_ack   <= '0;
            if (slot_strobe) begin
                char_load <= 1'b1;
                char_out  <= NULL_CHAR;
            end

            case (state)
                ST_DISABLED: begin
                    link_up <= 1'b0;
                    if (link_en) begin
                        state   <= ST_PREAMBLE;
                        pre_cnt <= '0;
                    end
                end
                ST_PREAMBLE: begin
                    if (!link_en) begin
                        state <= ST_DISABLED;
                    end else if (slot_strobe) begin
                        pre_cnt <= pre_cnt + 8'd1;
                        if (pre_cnt == 8'(G_NULL_PRE - 1)) begin
                            state   <= ST_RUN;
                            link_up <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // A falling link_en wins over a grant in the same strobe cycle.
                    if (!link_en) begin
                        state   <= ST_DISABLED;
                        link_up <= 1'b0;
                    end else if (slot_strobe && grant_found) begin
                        char_out      <= req_char[grant_idx];
                        req_ack       <= G_NUM_REQ'(1) << grant_idx;
                        tx_char_count <= tx_char_count + 16'd1;
                        rr_ptr        <= (grant_idx == PTR_W'(G_NUM_REQ - 1)) ? '0
                                                                               : grant_idx + 1'b1;
                    end
                end
                default: state <= ST_DISABLED;
            endcase
        end
    end

endmodule

// File: tb/tb_ieee1355_tx_scheduler.sv
// Bench for ieee1355_tx_scheduler: slot-level behavioural model compared every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_ieee1355_tx_scheduler;

    localparam int N    = 4;
    localparam int CPB  = 4;
    localparam int NPRE = 8;
    localparam int SLOT = 10 * CPB;
    localparam logic [9:0] NULL_CHAR = 10'b1111000110;

    logic              clk_x4    = 1'b0;
    logic              rst_n     = 1'b0;
    logic              link_en   = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [10*N-1:0]   req_data  = '0;
    logic [N-1:0]      req_ack;
    logic [9:0]        char_out;
    logic              char_load;
    logic              bit_en;
    logic              link_up;
    logic [15:0]       tx_char_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: link activity, remaining preamble NULLs, round-robin pointer, expected outputs.
    bit          m_active;
    int          m_pre_left;
    int          m_rr;
    logic [9:0]  exp_char;
    logic [N-1:0] exp_ack;
    logic        exp_load;
    logic        exp_bit_en;
    logic        exp_link_up;
    logic [15:0] exp_cnt;
    bit          drop_on_ack;

    ieee1355_tx_scheduler #(
        .G_NUM_REQ(N), .G_CLK_PER_BIT(CPB), .G_NULL_PRE(NPRE)
    ) dut (
        .clk_x4(clk_x4), .rst_n(rst_n), .link_en(link_en),
        .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
        .char_out(char_out), .char_load(char_load), .bit_en(bit_en),
        .link_up(link_up), .tx_char_count(tx_char_count)
    );

    always #5 clk_x4 = ~clk_x4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc        = 0;
        m_active   = 1'b0;
        m_pre_left = 0;
        m_rr       = 0;
        exp_char   = NULL_CHAR;
        exp_ack    = '0;
        exp_cnt    = '0;
    endtask

    // Evaluated on pre-edge inputs; yields the outputs expected after the coming edge.
    task automatic model_step();
        bit strobe;
        int g;
        int idx;
        strobe   = (cyc > 0) && (cyc % SLOT == 0);
        g        = -1;
        exp_load = strobe;
        exp_ack  = '0;
        if (strobe) begin
            exp_char = NULL_CHAR;
            if (m_active && link_en) begin
                if (m_pre_left > 0) begin
                    m_pre_left--;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        idx = (m_rr + k) % N;
                        if (g < 0 && req_valid[idx]) g = idx;
                    end
                    if (g >= 0) begin
                        exp_char   = req_data[g*10 +: 10];
                        exp_ack[g] = 1'b1;
                        exp_cnt    = exp_cnt + 16'd1;
                        m_rr       = (g + 1) % N;
                    end
                end
            end
        end
        if (!link_en) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active   = 1'b1;
            m_pre_left = NPRE;
        end
        exp_link_up = m_active && (m_pre_left == 0);
        exp_bit_en  = ((cyc + 1) >= CPB) && ((cyc + 1) % CPB == 0);
    endtask

    task automatic step();
        model_step();
        @(posedge clk_x4);
        #1;
        cyc++;
        check("bit_en",        32'(bit_en),        32'(exp_bit_en));
        check("char_load",     32'(char_load),     32'(exp_load));
        check("char_out",      32'(char_out),      32'(exp_char));
        check("req_ack",       32'(req_ack),       32'(exp_ack));
        check("link_up",       32'(link_up),       32'(exp_link_up));
        check("tx_char_count", 32'(tx_char_count), 32'(exp_cnt));
        if (drop_on_ack) req_valid = req_valid & ~exp_ack;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_x4);
        @(negedge clk_x4);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic set_data(input int i, input logic [9:0] d);
        req_data[i*10 +: 10] = d;
    endtask

    initial begin
        int loads, acks, first_load, second_load, up_cyc, grant_cyc, grant_load;
        logic [N-1:0] grant_ack;
        logic [9:0]   grant_char;
        logic [9:0]   seq_char [5];
        logic [N-1:0] seq_ack  [5];
        logic [9:0]   exp_seq_char [5];
        logic [N-1:0] exp_seq_ack  [5];
        bit           prev_up;

        // Reset value check, then link up with requester 2 pending from release.
        link_en     = 1'b1;
        req_valid   = 4'b0100;
        set_data(2, 10'h155);
        drop_on_ack = 1'b1;
        do_reset();
        check("rst_char_out",  32'(char_out),      32'(NULL_CHAR));
        check("rst_link_up",   32'(link_up),       32'd0);
        check("rst_count",     32'(tx_char_count), 32'd0);
        check("rst_load_ack",  32'({char_load, bit_en, req_ack}), 32'd0);

        loads = 0; first_load = 0; second_load = 0; up_cyc = 0; grant_cyc = 0;
        grant_load = 0; grant_ack = '0; grant_char = '0; prev_up = 1'b0;
        for (int t = 0; t < 420; t++) begin
            step();
            if (char_load) begin
                loads++;
                if (loads == 1) first_load = cyc;
                if (loads == 2) second_load = cyc;
            end
            if (link_up && !prev_up && up_cyc == 0) up_cyc = cyc;
            prev_up = link_up;
            if (req_ack != '0 && grant_cyc == 0) begin
                grant_cyc  = cyc;
                grant_load = loads;
                grant_ack  = req_ack;
                grant_char = char_out;
            end
        end
        check("t1_first_load",   32'(first_load),   32'd41);
        check("t1_load_period",  32'(second_load - first_load), 32'd40);
        check("t1_link_up_rise", 32'(up_cyc),       32'd321);
        check("t2_grant_load",   32'(grant_load),   32'd9);
        check("t2_grant_cycle",  32'(grant_cyc),    32'd361);
        check("t2_grant_ack",    32'(grant_ack),    32'b0100);
        check("t2_grant_char",   32'(grant_char),   32'h155);
        check("t2_count",        32'(tx_char_count), 32'd1);

        // All four requesters continuously valid: round-robin 0,1,2,3,0.
        req_valid   = 4'b1111;
        set_data(0, 10'h001); set_data(1, 10'h002); set_data(2, 10'h003); set_data(3, 10'h004);
        drop_on_ack = 1'b0;
        do_reset();
        exp_seq_char = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h001};
        exp_seq_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin seq_char[i] = '0; seq_ack[i] = '0; end
        acks = 0;
        for (int t = 0; t < 600 && acks < 5; t++) begin
            step();
            if (req_ack != '0) begin
                seq_char[acks] = char_out;
                seq_ack[acks]  = req_ack;
                acks++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_char%0d", i), 32'(seq_char[i]), 32'(exp_seq_char[i]));
            check($sformatf("t3_ack%0d", i),  32'(seq_ack[i]),  32'(exp_seq_ack[i]));
        end

        // link_en dropped in RUN with requester 1 held; re-enable needs a full preamble.
        drop_on_ack = 1'b1;
        req_valid   = 4'b0010;
        set_data(1, 10'h2AA);
        link_en     = 1'b0;
        step();
        check("t4_link_down", 32'(link_up), 32'd0);
        acks = 0;
        for (int t = 0; t < 120; t++) begin
            step();
            if (req_ack != '0) acks++;
        end
        check("t4_no_ack_disabled", 32'(acks), 32'd0);
        link_en = 1'b1;
        loads = 0; grant_ack = '0; grant_char = '0; grant_load = 0;
        for (int t = 0; t < 500 && grant_ack == '0; t++) begin
            step();
            if (char_load) loads++;
            if (req_ack != '0) begin
                grant_ack  = req_ack;
                grant_char = char_out;
                grant_load = loads;
            end
        end
        check("t4_regrant_load", 32'(grant_load), 32'd9);
        check("t4_regrant_ack",  32'(grant_ack),  32'b0010);
        check("t4_regrant_char", 32'(grant_char), 32'h2AA);

        // link_en falls exactly on the strobe cycle with requester 0 pending.
        req_valid = 4'b0001;
        set_data(0, 10'h0F0);
        acks = 0;
        for (int t = 0; t < 2*SLOT && (cyc % SLOT) != 0; t++) begin
            step();
            if (req_ack != '0) acks++;
        end
        link_en = 1'b0;
        step();
        check("t5_load",      32'(char_load), 32'd1);
        check("t5_null",      32'(char_out),  32'(NULL_CHAR));
        check("t5_ack",       32'(req_ack | N'(acks)), 32'd0);
        check("t5_link_up",   32'(link_up),   32'd0);

        // Asynchronous reset mid-slot once five characters have gone out.
        link_en     = 1'b1;
        req_valid   = 4'b1111;
        drop_on_ack = 1'b0;
        do_reset();
        for (int t = 0; t < 700 && exp_cnt != 16'd5; t++) step();
        check("t6_count_before", 32'(tx_char_count), 32'd5);
        repeat (13) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_count",    32'(tx_char_count), 32'd0);
        check("t6_rst_char_out", 32'(char_out),      32'(NULL_CHAR));
        check("t6_rst_link_up",  32'(link_up),       32'd0);
        check("t6_rst_strobes",  32'({char_load, bit_en, req_ack}), 32'd0);
        do_reset();
        up_cyc = 0; prev_up = 1'b0;
        for (int t = 0; t < 340; t++) begin
            step();
            if (link_up && !prev_up && up_cyc == 0) up_cyc = cyc;
            prev_up = link_up;
        end
        check("t6_preamble_restart", 32'(up_cyc), 32'd321);

        // Randomized traffic with withdrawals and link toggling.
        req_valid   = '0;
        drop_on_ack = 1'b0;
        link_en     = 1'b1;
        do_reset();
        for (int t = 0; t < 12000; t++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (exp_ack[i]) begin
                    if ($urandom_range(1, 0) == 1) set_data(i, 10'($urandom));
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(15, 0) == 0) begin
                        set_data(i, 10'($urandom));
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(255, 0) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            if ($urandom_range(999, 0) == 0) link_en = ~link_en;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
